// File: rtl/nm_cluster_fabric.sv
// nm_cluster_fabric: network top for the neuron-cluster array.
// Owns reset stretching, standby, the Network Status Register (NSR) and the
// CLUSTER_MASK register. It merges the wired-AND/OR buses of NUM_CLUSTERS
// clusters and routes the DCI/DCO daisy chain past masked clusters.
// Optional feature macro: NM_BUS_PIPE_EN registers the merged ready/id/unc
// results and the read data, adding one cycle of latency. The daisy chain
// stays combinational in both builds.
module nm_cluster_fabric #(
    parameter int         NUM_CLUSTERS = 3,
    parameter int         RESET_HOLD   = 255,
    parameter logic [3:0] MASK_REG     = 4'hE
) (
    input  logic                       G_CLK,
    input  logic                       G_RESET,
    input  logic                       CS_l,
    input  logic                       DS,
    input  logic                       RW_l,
    input  logic [3:0]                 REG,
    input  logic [15:0]                data_in,
    output logic [15:0]                data_out_n,
    input  logic                       id_l_in,
    input  logic                       unc_l_in,
    output logic                       id_l_t,
    output logic                       unc_l_t,
    input  logic                       DCI,
    output logic                       DCO,
    output logic                       RDY,
    output logic [NUM_CLUSTERS-1:0]    clu_clk_en,
    output logic                       clu_reset_l,
    output logic                       nsr_sr,
    output logic                       nsr_knn,
    input  logic [16*NUM_CLUSTERS-1:0] clu_data_out_n,
    input  logic [NUM_CLUSTERS-1:0]    clu_ready,
    input  logic [NUM_CLUSTERS-1:0]    clu_id,
    input  logic [NUM_CLUSTERS-1:0]    clu_unclearn,
    input  logic [NUM_CLUSTERS-1:0]    clu_dco,
    output logic [NUM_CLUSTERS-1:0]    clu_dci
);

    localparam int         CNT_W      = $clog2(RESET_HOLD + 1);
    localparam logic [3:0] NSR_REG    = 4'hD;
    localparam logic [3:0] FORGET_REG = 4'hF;

    logic [CNT_W-1:0]        hold_cnt;
    logic                    rst_done;
    logic                    standby_r;
    logic                    forget_r;
    logic [15:0]             nsr;
    logic [NUM_CLUSTERS-1:0] mask;
    logic                    wr_stb;

    logic                    ready_c, id_c, unc_c;
    logic [15:0]             bus_c;
    logic [15:0]             rd_c;
    logic                    ready_m, id_m, unc_m;
    logic [15:0]             data_m;
    logic [NUM_CLUSTERS:0]   chain;

    // Register writes only land while the chip is out of standby.
    assign wr_stb = DS & ~RW_l & ~standby_r;

    // Reset stretcher: hold the network in reset for RESET_HOLD cycles after
    // G_RESET drops; rst_done is registered so the release lands one cycle later.
    always_ff @(posedge G_CLK) begin
        if (G_RESET) begin
            hold_cnt <= CNT_W'(RESET_HOLD);
            rst_done <= 1'b0;
        end else begin
            if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - CNT_W'(1);
            end
            rst_done <= (hold_cnt == '0);
        end
    end

    // Standby tracking and the one-cycle FORGET pulse.
    always_ff @(posedge G_CLK) begin
        if (G_RESET) begin
            standby_r <= 1'b0;
            forget_r  <= 1'b0;
        end else begin
            standby_r <= CS_l;
            forget_r  <= wr_stb && (REG == FORGET_REG);
        end
    end

    // CLUSTER_MASK register; all clusters active out of reset.
    always_ff @(posedge G_CLK) begin
        if (G_RESET) begin
            mask <= '1;
        end else if (wr_stb && (REG == MASK_REG)) begin
            mask <= data_in[NUM_CLUSTERS-1:0];
        end
    end

    // NSR: a host write wins over the live ID/UNC status sampling.
    always_ff @(posedge G_CLK) begin
        if (G_RESET) begin
            nsr <= '0;
        end else if (wr_stb && (REG == NSR_REG)) begin
            nsr <= data_in;
        end else if (!standby_r) begin
            nsr[3] <= ~id_l_in;
            nsr[2] <= ~unc_l_in;
        end
    end

    // Bus merge: a masked cluster contributes the identity of each operator.
    always_comb begin
        ready_c = 1'b1;
        id_c    = 1'b0;
        unc_c   = 1'b1;
        bus_c   = 16'hFFFF;
        for (int i = 0; i < NUM_CLUSTERS; i++) begin
            ready_c = ready_c & (clu_ready[i] | ~mask[i]);
            id_c    = id_c | (clu_id[i] & mask[i]);
            unc_c   = unc_c & (clu_unclearn[i] | ~mask[i]);
            bus_c   = bus_c & (clu_data_out_n[16*i +: 16] | {16{~mask[i]}});
        end
    end

    // Read mux: local registers are ANDed onto the cluster bus; writes release the pads.
    always_comb begin
        rd_c = 16'hFFFF;
        if (RW_l) begin
            rd_c = bus_c;
            if (!standby_r && (REG == NSR_REG)) begin
                rd_c = bus_c & nsr;
            end else if (!standby_r && (REG == MASK_REG)) begin
                rd_c = bus_c & 16'(mask);
            end
        end
    end

`ifdef NM_BUS_PIPE_EN
    // Stage p1: merged bus results and read data registered after the merge.
    always_ff @(posedge G_CLK) begin
        if (G_RESET) begin
            ready_m <= 1'b0;
            id_m    <= 1'b0;
            unc_m   <= 1'b1;
            data_m  <= 16'hFFFF;
        end else begin
            ready_m <= ready_c;
            id_m    <= id_c;
            unc_m   <= unc_c;
            data_m  <= rd_c;
        end
    end
`else
    // Merged results pass straight through with no added latency.
    always_comb begin
        ready_m = ready_c;
        id_m    = id_c;
        unc_m   = unc_c;
        data_m  = rd_c;
    end
`endif

    // Daisy chain: a masked cluster is bypassed by forwarding its DCI onward.
    always_comb begin
        chain    = '0;
        chain[0] = DCI;
        for (int i = 0; i < NUM_CLUSTERS; i++) begin
            chain[i+1] = mask[i] ? clu_dco[i] : chain[i];
        end
    end

    assign clu_dci     = chain[NUM_CLUSTERS-1:0];
    assign DCO         = chain[NUM_CLUSTERS];
    assign clu_clk_en  = {NUM_CLUSTERS{~standby_r}} & mask;
    assign clu_reset_l = rst_done & ~forget_r;
    assign RDY         = rst_done & ready_m;
    assign data_out_n  = data_m;
    assign id_l_t      = ~(id_m & unc_l_in);
    assign unc_l_t     = unc_m;
    assign nsr_sr      = nsr[4];
    assign nsr_knn     = nsr[5];

endmodule

// File: tb/tb_nm_cluster_fabric.sv
// Testbench for nm_cluster_fabric with three clusters and a short reset hold.
module tb_nm_cluster_fabric;

    localparam int         N    = 3;
    localparam int         HOLD = 4;
    localparam logic [3:0] MREG = 4'hE;
`ifdef NM_BUS_PIPE_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic            G_CLK;
    logic            G_RESET;
    logic            CS_l, DS, RW_l;
    logic [3:0]      REG;
    logic [15:0]     data_in;
    logic [15:0]     data_out_n;
    logic            id_l_in, unc_l_in;
    logic            id_l_t, unc_l_t;
    logic            DCI, DCO, RDY;
    logic [N-1:0]    clu_clk_en;
    logic            clu_reset_l;
    logic            nsr_sr, nsr_knn;
    logic [16*N-1:0] clu_data_out_n;
    logic [N-1:0]    clu_ready, clu_id, clu_unclearn, clu_dco, clu_dci;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: last value written to NSR and the current mask.
    logic [15:0]  nsr_w;
    logic [N-1:0] mask_m;

    nm_cluster_fabric #(
        .NUM_CLUSTERS(N),
        .RESET_HOLD  (HOLD),
        .MASK_REG    (MREG)
    ) dut (
        .G_CLK         (G_CLK),
        .G_RESET       (G_RESET),
        .CS_l          (CS_l),
        .DS            (DS),
        .RW_l          (RW_l),
        .REG           (REG),
        .data_in       (data_in),
        .data_out_n    (data_out_n),
        .id_l_in       (id_l_in),
        .unc_l_in      (unc_l_in),
        .id_l_t        (id_l_t),
        .unc_l_t       (unc_l_t),
        .DCI           (DCI),
        .DCO           (DCO),
        .RDY           (RDY),
        .clu_clk_en    (clu_clk_en),
        .clu_reset_l   (clu_reset_l),
        .nsr_sr        (nsr_sr),
        .nsr_knn       (nsr_knn),
        .clu_data_out_n(clu_data_out_n),
        .clu_ready     (clu_ready),
        .clu_id        (clu_id),
        .clu_unclearn  (clu_unclearn),
        .clu_dco       (clu_dco),
        .clu_dci       (clu_dci)
    );

    initial begin
        G_CLK = 1'b0;
        forever #5 G_CLK = ~G_CLK;
    end

    task automatic tick();
        @(posedge G_CLK);
        #2;
    endtask

    task automatic settle();
        repeat (1 + LAT) tick();
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        DS = 1'b1; RW_l = 1'b0; REG = a; data_in = d;
        tick();
        DS = 1'b0; RW_l = 1'b1; REG = 4'h0;
    endtask

    // NSR as seen after an enabled cycle: written value with live ID/UNC status.
    function automatic logic [15:0] nsr_now();
        logic [15:0] v;
        v = nsr_w & 16'hFFF3;
        v[3] = ~id_l_in;
        v[2] = ~unc_l_in;
        return v;
    endfunction

    // Wired-AND of the data buses of the clusters that are switched on.
    function automatic logic [15:0] bus_model(input logic [N-1:0] m, input logic [16*N-1:0] d);
        logic [15:0] b;
        b = 16'hFFFF;
        for (int i = 0; i < N; i++) if (m[i]) b = b & d[16*i +: 16];
        return b;
    endfunction

    // Each cluster's DCI comes from the nearest enabled cluster below it, else the chip DCI.
    function automatic logic [N-1:0] dci_model(input logic [N-1:0] m, input logic [N-1:0] dco, input logic din);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            r[i] = din;
            for (int j = 0; j < i; j++) if (m[j]) r[i] = dco[j];
        end
        return r;
    endfunction

    function automatic logic dco_model(input logic [N-1:0] m, input logic [N-1:0] dco, input logic din);
        logic r;
        r = din;
        for (int j = 0; j < N; j++) if (m[j]) r = dco[j];
        return r;
    endfunction

    task automatic test_reset();
        G_RESET = 1'b1;
        tick(); tick();
        #1;
        n_tests++; if (RDY !== 1'b0) begin n_fail++; $display("FAIL reset_rdy got=%b exp=0", RDY); end
        n_tests++; if (clu_reset_l !== 1'b0) begin n_fail++; $display("FAIL reset_clu_reset_l got=%b exp=0", clu_reset_l); end
        n_tests++; if (clu_clk_en !== 3'b111) begin n_fail++; $display("FAIL reset_clk_en got=%b exp=111", clu_clk_en); end
        n_tests++; if (data_out_n !== 16'hFFFF) begin n_fail++; $display("FAIL reset_data got=%h exp=ffff", data_out_n); end
        n_tests++; if (id_l_t !== 1'b1) begin n_fail++; $display("FAIL reset_id_l_t got=%b exp=1", id_l_t); end
        n_tests++; if (unc_l_t !== 1'b1) begin n_fail++; $display("FAIL reset_unc_l_t got=%b exp=1", unc_l_t); end
        G_RESET = 1'b0;
        for (int k = 0; k <= HOLD + 2; k++) begin
            logic exp;
            if (k > 0) tick();
            #1;
            exp = (k >= HOLD + 1);
            n_tests++; if (RDY !== exp) begin n_fail++; $display("FAIL stretch_rdy k=%0d got=%b exp=%b", k, RDY, exp); end
            n_tests++; if (clu_reset_l !== exp) begin n_fail++; $display("FAIL stretch_clu_reset_l k=%0d got=%b exp=%b", k, clu_reset_l, exp); end
        end
        nsr_w = 16'h0000;
        mask_m = '1;
    endtask

    task automatic test_nsr_rw();
        clu_data_out_n = '1; id_l_in = 1'b1; unc_l_in = 1'b1;
        wr(4'hD, 16'h0030);
        nsr_w = 16'h0030;
        REG = 4'hD;
        settle(); #1;
        n_tests++; if (data_out_n !== 16'h0030) begin n_fail++; $display("FAIL nsr_read got=%h exp=0030", data_out_n); end
        n_tests++; if ({nsr_knn, nsr_sr} !== 2'b11) begin n_fail++; $display("FAIL nsr_export got=%b exp=11", {nsr_knn, nsr_sr}); end
        id_l_in = 1'b0;
        settle(); #1;
        n_tests++; if (data_out_n !== 16'h0038) begin n_fail++; $display("FAIL nsr_id_status got=%h exp=0038", data_out_n); end
        id_l_in = 1'b1;
        settle();
    endtask

    task automatic test_daisy();
        wr(MREG, 16'hFFF5);
        mask_m = 3'b101;
        DCI = 1'b1; clu_dco = 3'b000; clu_ready = 3'b101;
        settle(); #1;
        n_tests++; if (clu_dci !== 3'b001) begin n_fail++; $display("FAIL daisy_dci got=%b exp=001", clu_dci); end
        n_tests++; if (DCO !== 1'b0) begin n_fail++; $display("FAIL daisy_dco0 got=%b exp=0", DCO); end
        n_tests++; if (RDY !== 1'b1) begin n_fail++; $display("FAIL daisy_rdy_masked got=%b exp=1", RDY); end
        clu_dco = 3'b100; #1;
        n_tests++; if (DCO !== 1'b1) begin n_fail++; $display("FAIL daisy_dco1 got=%b exp=1", DCO); end
        clu_dco = 3'b001; #1;
        n_tests++; if (clu_dci !== 3'b111) begin n_fail++; $display("FAIL daisy_bypass got=%b exp=111", clu_dci); end
        n_tests++; if (DCO !== 1'b0) begin n_fail++; $display("FAIL daisy_dco2 got=%b exp=0", DCO); end
        clu_ready = '1;
    endtask

    task automatic test_merge();
        logic [15:0] md, bus, exp_data;
        logic        e_ready, e_id, e_unc;
        int          sel;
        for (int it = 0; it < 24; it++) begin
            md = 16'($urandom());
            if (it == 0) md[N-1:0] = '0;
            if (it == 1) md[N-1:0] = '1;
            wr(MREG, md);
            mask_m = md[N-1:0];
            clu_ready      = N'($urandom());
            clu_id         = N'($urandom());
            clu_unclearn   = N'($urandom());
            clu_dco        = N'($urandom());
            clu_data_out_n = 48'({$urandom(), $urandom()});
            DCI      = 1'($urandom_range(0, 1));
            id_l_in  = 1'($urandom_range(0, 1));
            unc_l_in = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 2);
            REG = (sel == 0) ? 4'hD : (sel == 1) ? MREG : 4'h3;
            settle(); #1;
            e_ready = ((~clu_ready & mask_m) == '0);
            e_id    = ((clu_id & mask_m) != '0);
            e_unc   = ((~clu_unclearn & mask_m) == '0);
            bus     = bus_model(mask_m, clu_data_out_n);
            exp_data = (sel == 0) ? (bus & nsr_now()) : (sel == 1) ? (bus & {13'b0, mask_m}) : bus;
            n_tests++; if (RDY !== e_ready) begin n_fail++; $display("FAIL merge_rdy it=%0d got=%b exp=%b", it, RDY, e_ready); end
            n_tests++; if (id_l_t !== ~(e_id & unc_l_in)) begin n_fail++; $display("FAIL merge_id it=%0d got=%b exp=%b", it, id_l_t, ~(e_id & unc_l_in)); end
            n_tests++; if (unc_l_t !== e_unc) begin n_fail++; $display("FAIL merge_unc it=%0d got=%b exp=%b", it, unc_l_t, e_unc); end
            n_tests++; if (data_out_n !== exp_data) begin n_fail++; $display("FAIL merge_data it=%0d got=%h exp=%h", it, data_out_n, exp_data); end
            n_tests++; if (DCO !== dco_model(mask_m, clu_dco, DCI)) begin n_fail++; $display("FAIL merge_dco it=%0d got=%b exp=%b", it, DCO, dco_model(mask_m, clu_dco, DCI)); end
            n_tests++; if (clu_dci !== dci_model(mask_m, clu_dco, DCI)) begin n_fail++; $display("FAIL merge_dci it=%0d got=%b exp=%b", it, clu_dci, dci_model(mask_m, clu_dco, DCI)); end
            n_tests++; if (clu_clk_en !== mask_m) begin n_fail++; $display("FAIL merge_clk_en it=%0d got=%b exp=%b", it, clu_clk_en, mask_m); end
        end
        clu_ready = '1; clu_id = '0; clu_unclearn = '1; clu_data_out_n = '1;
        id_l_in = 1'b1; unc_l_in = 1'b1;
        settle();
    endtask

    task automatic test_forget();
        wr(4'hF, 16'h1234); #1;
        n_tests++; if (clu_reset_l !== 1'b0) begin n_fail++; $display("FAIL forget_pulse got=%b exp=0", clu_reset_l); end
        tick(); #1;
        n_tests++; if (clu_reset_l !== 1'b1) begin n_fail++; $display("FAIL forget_end got=%b exp=1", clu_reset_l); end
        DS = 1'b1; RW_l = 1'b0; REG = 4'hF;
        tick(); #1;
        n_tests++; if (clu_reset_l !== 1'b0) begin n_fail++; $display("FAIL forget_sustain1 got=%b exp=0", clu_reset_l); end
        tick();
        DS = 1'b0; RW_l = 1'b1; REG = 4'hD; #1;
        n_tests++; if (clu_reset_l !== 1'b0) begin n_fail++; $display("FAIL forget_sustain2 got=%b exp=0", clu_reset_l); end
        tick(); #1;
        n_tests++; if (clu_reset_l !== 1'b1) begin n_fail++; $display("FAIL forget_sustain_end got=%b exp=1", clu_reset_l); end
        settle(); #1;
        n_tests++; if (data_out_n !== nsr_now()) begin n_fail++; $display("FAIL forget_nsr_kept got=%h exp=%h", data_out_n, nsr_now()); end
        REG = MREG;
        settle(); #1;
        n_tests++; if (data_out_n !== {13'b0, mask_m}) begin n_fail++; $display("FAIL forget_mask_kept got=%h exp=%h", data_out_n, {13'b0, mask_m}); end
    endtask

    task automatic test_standby();
        wr(MREG, 16'h0007);
        mask_m = 3'b111;
        CS_l = 1'b1;
        tick(); #1;
        n_tests++; if (clu_clk_en !== 3'b000) begin n_fail++; $display("FAIL standby_clk_en0 got=%b exp=000", clu_clk_en); end
        DS = 1'b1; RW_l = 1'b0; REG = 4'hD; data_in = 16'h00FF;
        id_l_in = 1'b0;
        tick(); #1;
        n_tests++; if (clu_clk_en !== 3'b000) begin n_fail++; $display("FAIL standby_clk_en1 got=%b exp=000", clu_clk_en); end
        tick(); #1;
        n_tests++; if (clu_clk_en !== 3'b000) begin n_fail++; $display("FAIL standby_clk_en2 got=%b exp=000", clu_clk_en); end
        id_l_in = 1'b1;
        CS_l = 1'b0; DS = 1'b0; RW_l = 1'b1;
        tick(); #1;
        n_tests++; if (clu_clk_en !== 3'b111) begin n_fail++; $display("FAIL standby_wake got=%b exp=111", clu_clk_en); end
        settle(); #1;
        n_tests++; if (data_out_n !== nsr_now()) begin n_fail++; $display("FAIL standby_write_lost got=%h exp=%h", data_out_n, nsr_now()); end
    endtask

    task automatic test_id_latency();
        clu_id = '0; unc_l_in = 1'b1;
        settle(); #1;
        n_tests++; if (id_l_t !== 1'b1) begin n_fail++; $display("FAIL id_idle got=%b exp=1", id_l_t); end
        clu_id[0] = 1'b1; #1;
        n_tests++; if (id_l_t !== ((LAT == 1) ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL id_immediate got=%b exp=%0d", id_l_t, (LAT == 1)); end
        tick(); #1;
        n_tests++; if (id_l_t !== 1'b0) begin n_fail++; $display("FAIL id_after_edge got=%b exp=0", id_l_t); end
        clu_id = '0;
        settle();
    endtask

    task automatic test_reset_mid();
        wr(4'hD, 16'h00F0);
        wr(MREG, 16'h0002);
        G_RESET = 1'b1;
        tick(); #1;
        n_tests++; if (RDY !== 1'b0) begin n_fail++; $display("FAIL mid_rdy got=%b exp=0", RDY); end
        n_tests++; if (clu_clk_en !== 3'b111) begin n_fail++; $display("FAIL mid_mask got=%b exp=111", clu_clk_en); end
        n_tests++; if ({nsr_knn, nsr_sr} !== 2'b00) begin n_fail++; $display("FAIL mid_nsr got=%b exp=00", {nsr_knn, nsr_sr}); end
        G_RESET = 1'b0;
        nsr_w = 16'h0000; mask_m = '1;
        repeat (HOLD + 1) tick();
        #1;
        n_tests++; if (RDY !== 1'b1) begin n_fail++; $display("FAIL mid_recover got=%b exp=1", RDY); end
        REG = 4'hD;
        settle(); #1;
        n_tests++; if (data_out_n !== nsr_now()) begin n_fail++; $display("FAIL mid_nsr_read got=%h exp=%h", data_out_n, nsr_now()); end
    endtask

    initial begin
        G_RESET = 1'b1; CS_l = 1'b0; DS = 1'b0; RW_l = 1'b0; REG = 4'h0;
        data_in = '0; id_l_in = 1'b1; unc_l_in = 1'b1; DCI = 1'b0;
        clu_data_out_n = '1; clu_ready = '1; clu_id = '0; clu_unclearn = '1; clu_dco = '0;
        nsr_w = '0; mask_m = '1;
        test_reset();
        test_nsr_rw();
        test_daisy();
        test_merge();
        test_forget();
        test_standby();
        test_id_latency();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
